alu_rs: RTL and testbench

Reservation station for the integer ALU execution unit. It accepts decoded ALU instructions from the issue stage and holds them until both operands are available, snooping the common data bus (CDB) for missing values. It dispatches ready entries to the ALU with the entry index as tag, stores the ALU result back into the originating entry, and arbitrates for the CDB to broadcast the result with its ROB tag.

---
 rtl/alu_rs.sv | 212 +++++++++++++++++++++
 tb/tb_alu_rs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers issued ops until operands arrive,
// dispatches ready entries by entry index, and broadcasts completed results on the CDB.
//
// state      | meaning
// -----------+------------------------------------------------------------
// EMPTY      | slot free, may be allocated by issue
// WAIT_OPS   | allocated, at least one operand pending on a CDB tag
// READY_EX   | both operands valid, waiting for the ALU to accept
// EXECUTING  | dispatched, waiting for the ALU writeback on this index
// DONE       | result held, requesting the CDB
module alu_rs #(
    parameter int unsigned RS_DEPTH    = 8,
    parameter int unsigned ROB_IDX_LEN = 4,
    parameter int unsigned EU_CTL_LEN  = 4,
    parameter int unsigned EXCEPT_LEN  = 2,
    parameter int unsigned XLEN        = 64,
    localparam int unsigned IDX_LEN    = $clog2(RS_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,

    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i,
    input  logic                   issue_rs1_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
    input  logic [XLEN-1:0]        issue_rs1_value_i,
    input  logic                   issue_rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
    input  logic [XLEN-1:0]        issue_rs2_value_i,
    input  logic [ROB_IDX_LEN-1:0] issue_dest_idx_i,

    output logic                   eu_valid_o,
    input  logic                   eu_ready_i,
    output logic [EU_CTL_LEN-1:0]  eu_ctl_o,
    output logic [XLEN-1:0]        eu_rs1_o,
    output logic [XLEN-1:0]        eu_rs2_o,
    output logic [IDX_LEN-1:0]     eu_entry_idx_o,

    input  logic                   eu_valid_i,
    output logic                   eu_ready_o,
    input  logic [IDX_LEN-1:0]     eu_entry_idx_i,
    input  logic [XLEN-1:0]        eu_result_i,
    input  logic                   eu_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]  eu_except_code_i,

    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_idx_i,
    input  logic [XLEN-1:0]        cdb_value_i,

    output logic                   cdb_valid_o,
    input  logic                   cdb_ready_i,
    output logic [ROB_IDX_LEN-1:0] cdb_idx_o,
    output logic [XLEN-1:0]        cdb_value_o,
    output logic                   cdb_except_raised_o,
    output logic [EXCEPT_LEN-1:0]  cdb_except_code_o
);

    typedef enum logic [2:0] {
        EMPTY     = 3'd0,
        WAIT_OPS  = 3'd1,
        READY_EX  = 3'd2,
        EXECUTING = 3'd3,
        DONE      = 3'd4
    } state_e;

    typedef struct packed {
        logic [EU_CTL_LEN-1:0]  ctl;
        logic [ROB_IDX_LEN-1:0] dest;
        logic                   rs1_rdy;
        logic [ROB_IDX_LEN-1:0] rs1_tag;
        logic [XLEN-1:0]        rs1_val;
        logic                   rs2_rdy;
        logic [ROB_IDX_LEN-1:0] rs2_tag;
        logic [XLEN-1:0]        rs2_val;
        logic [XLEN-1:0]        res;
        logic                   exc;
        logic [EXCEPT_LEN-1:0]  exc_code;
    } entry_t;

    state_e st_q  [RS_DEPTH];
    state_e st_d  [RS_DEPTH];
    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];

    logic               free_found, rdy_found, done_found;
    logic [IDX_LEN-1:0] free_idx, rdy_idx, done_idx;

    // Incoming operands may be satisfied by the CDB in the very cycle they issue
    logic            iss_rs1_rdy, iss_rs2_rdy;
    logic [XLEN-1:0] iss_rs1_val, iss_rs2_val;

    assign iss_rs1_rdy = issue_rs1_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs1_idx_i));
    assign iss_rs2_rdy = issue_rs2_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs2_idx_i));
    assign iss_rs1_val = issue_rs1_ready_i ? issue_rs1_value_i : cdb_value_i;
    assign iss_rs2_val = issue_rs2_ready_i ? issue_rs2_value_i : cdb_value_i;

    always_comb begin
        free_found = 1'b0;
        rdy_found  = 1'b0;
        done_found = 1'b0;
        free_idx   = '0;
        rdy_idx    = '0;
        done_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!free_found && st_q[i] == EMPTY) begin
                free_found = 1'b1;
                free_idx   = IDX_LEN'(i);
            end
            if (!rdy_found && st_q[i] == READY_EX) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_LEN'(i);
            end
            if (!done_found && st_q[i] == DONE) begin
                done_found = 1'b1;
                done_idx   = IDX_LEN'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                st_q[i]  <= EMPTY;
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                st_q[i]  <= st_d[i];
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Each event targets a distinct state, so per-entry cases never conflict
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            st_d[i]  = st_q[i];
            ent_d[i] = ent_q[i];
            case (st_q[i])
                EMPTY: begin
                    if (issue_valid_i && free_idx == IDX_LEN'(i)) begin
                        ent_d[i].ctl      = issue_eu_ctl_i;
                        ent_d[i].dest     = issue_dest_idx_i;
                        ent_d[i].rs1_rdy  = iss_rs1_rdy;
                        ent_d[i].rs1_tag  = issue_rs1_idx_i;
                        ent_d[i].rs1_val  = iss_rs1_val;
                        ent_d[i].rs2_rdy  = iss_rs2_rdy;
                        ent_d[i].rs2_tag  = issue_rs2_idx_i;
                        ent_d[i].rs2_val  = iss_rs2_val;
                        ent_d[i].res      = '0;
                        ent_d[i].exc      = 1'b0;
                        ent_d[i].exc_code = '0;
                        st_d[i] = (iss_rs1_rdy && iss_rs2_rdy) ? READY_EX : WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (cdb_valid_i && !ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_idx_i) begin
                        ent_d[i].rs1_rdy = 1'b1;
                        ent_d[i].rs1_val = cdb_value_i;
                    end
                    if (cdb_valid_i && !ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_idx_i) begin
                        ent_d[i].rs2_rdy = 1'b1;
                        ent_d[i].rs2_val = cdb_value_i;
                    end
                    if (ent_d[i].rs1_rdy && ent_d[i].rs2_rdy) begin
                        st_d[i] = READY_EX;
                    end
                end
                READY_EX: begin
                    if (eu_ready_i && rdy_idx == IDX_LEN'(i)) begin
                        st_d[i] = EXECUTING;
                    end
                end
                EXECUTING: begin
                    if (eu_valid_i && eu_entry_idx_i == IDX_LEN'(i)) begin
                        ent_d[i].res      = eu_result_i;
                        ent_d[i].exc      = eu_except_raised_i;
                        ent_d[i].exc_code = eu_except_code_i;
                        st_d[i] = DONE;
                    end
                end
                DONE: begin
                    if (cdb_ready_i && done_idx == IDX_LEN'(i)) begin
                        st_d[i] = EMPTY;
                    end
                end
                default: st_d[i] = EMPTY;
            endcase
            if (flush_i) begin
                st_d[i] = EMPTY;
            end
        end
    end

    assign issue_ready_o = free_found;

    assign eu_valid_o     = rdy_found;
    assign eu_ctl_o       = rdy_found ? ent_q[rdy_idx].ctl : '0;
    assign eu_rs1_o       = rdy_found ? ent_q[rdy_idx].rs1_val : '0;
    assign eu_rs2_o       = rdy_found ? ent_q[rdy_idx].rs2_val : '0;
    assign eu_entry_idx_o = rdy_idx;
    assign eu_ready_o     = 1'b1;

    assign cdb_valid_o         = done_found;
    assign cdb_idx_o           = done_found ? ent_q[done_idx].dest : '0;
    assign cdb_value_o         = done_found ? ent_q[done_idx].res : '0;
    assign cdb_except_raised_o = done_found ? ent_q[done_idx].exc : 1'b0;
    assign cdb_except_code_o   = done_found ? ent_q[done_idx].exc_code : '0;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: inputs change and outputs are sampled on the falling edge.
module tb_alu_rs;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i;
    logic        issue_valid_i, issue_ready_o;
    logic [3:0]  issue_eu_ctl_i;
    logic        issue_rs1_ready_i, issue_rs2_ready_i;
    logic [3:0]  issue_rs1_idx_i, issue_rs2_idx_i, issue_dest_idx_i;
    logic [63:0] issue_rs1_value_i, issue_rs2_value_i;
    logic        eu_valid_o, eu_ready_i;
    logic [3:0]  eu_ctl_o;
    logic [63:0] eu_rs1_o, eu_rs2_o;
    logic [2:0]  eu_entry_idx_o;
    logic        eu_valid_i, eu_ready_o;
    logic [2:0]  eu_entry_idx_i;
    logic [63:0] eu_result_i;
    logic        eu_except_raised_i;
    logic [1:0]  eu_except_code_i;
    logic        cdb_valid_i;
    logic [3:0]  cdb_idx_i;
    logic [63:0] cdb_value_i;
    logic        cdb_valid_o, cdb_ready_i;
    logic [3:0]  cdb_idx_o;
    logic [63:0] cdb_value_o;
    logic        cdb_except_raised_o;
    logic [1:0]  cdb_except_code_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    alu_rs dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_eu_ctl_i(issue_eu_ctl_i),
        .issue_rs1_ready_i(issue_rs1_ready_i), .issue_rs1_idx_i(issue_rs1_idx_i),
        .issue_rs1_value_i(issue_rs1_value_i),
        .issue_rs2_ready_i(issue_rs2_ready_i), .issue_rs2_idx_i(issue_rs2_idx_i),
        .issue_rs2_value_i(issue_rs2_value_i),
        .issue_dest_idx_i(issue_dest_idx_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o),
        .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_entry_idx_o(eu_entry_idx_o),
        .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_entry_idx_i(eu_entry_idx_i),
        .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i),
        .eu_except_code_i(eu_except_code_i),
        .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_value_i(cdb_value_i),
        .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_idx_o(cdb_idx_o),
        .cdb_value_o(cdb_value_o), .cdb_except_raised_o(cdb_except_raised_o),
        .cdb_except_code_o(cdb_except_code_o)
    );

    task automatic idle();
        flush_i = 1'b0; issue_valid_i = 1'b0; issue_eu_ctl_i = '0;
        issue_rs1_ready_i = 1'b0; issue_rs2_ready_i = 1'b0;
        issue_rs1_idx_i = '0; issue_rs2_idx_i = '0; issue_dest_idx_i = '0;
        issue_rs1_value_i = '0; issue_rs2_value_i = '0;
        eu_ready_i = 1'b0; eu_valid_i = 1'b0; eu_entry_idx_i = '0; eu_result_i = '0;
        eu_except_raised_i = 1'b0; eu_except_code_i = '0;
        cdb_valid_i = 1'b0; cdb_idx_i = '0; cdb_value_i = '0; cdb_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic issue(input logic [3:0] ctl, input logic r1, input logic [3:0] t1,
                         input logic [63:0] v1, input logic r2, input logic [3:0] t2,
                         input logic [63:0] v2, input logic [3:0] dest);
        issue_valid_i = 1'b1; issue_eu_ctl_i = ctl;
        issue_rs1_ready_i = r1; issue_rs1_idx_i = t1; issue_rs1_value_i = v1;
        issue_rs2_ready_i = r2; issue_rs2_idx_i = t2; issue_rs2_value_i = v2;
        issue_dest_idx_i = dest;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%0h exp=1", issue_ready_o); end
        total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL rst_eu_valid got=%0h exp=0", eu_valid_o); end
        total++; if (cdb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_cdb_valid got=%0h exp=0", cdb_valid_o); end
        total++; if (eu_ready_o !== 1'b1) begin bad++; $display("FAIL rst_eu_ready got=%0h exp=1", eu_ready_o); end
        total++; if (eu_rs1_o !== 64'h0 || eu_ctl_o !== 4'h0) begin bad++; $display("FAIL rst_eu_data got=%0h/%0h exp=0", eu_rs1_o, eu_ctl_o); end
        total++; if (cdb_value_o !== 64'h0 || cdb_idx_o !== 4'h0) begin bad++; $display("FAIL rst_cdb_data got=%0h/%0h exp=0", cdb_value_o, cdb_idx_o); end
    endtask

    task automatic test_basic();
        do_reset();
        issue(OP_ADD, 1'b1, 4'd0, 64'd5, 1'b1, 4'd0, 64'd7, 4'd3);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1 || eu_entry_idx_o !== 3'd0) begin bad++; $display("FAIL basic_dispatch got=%0h idx=%0h exp=1 idx=0", eu_valid_o, eu_entry_idx_o); end
        total++; if (eu_rs1_o !== 64'd5 || eu_rs2_o !== 64'd7 || eu_ctl_o !== OP_ADD) begin bad++; $display("FAIL basic_operands got=%0h/%0h/%0h exp=5/7/%0h", eu_rs1_o, eu_rs2_o, eu_ctl_o, OP_ADD); end
        eu_ready_i = 1'b1;
        @(negedge clk_i);
        eu_ready_i = 1'b0;
        total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL basic_executing got=%0h exp=0", eu_valid_o); end
        eu_valid_i = 1'b1; eu_entry_idx_i = 3'd0; eu_result_i = 64'd12;
        @(negedge clk_i);
        eu_valid_i = 1'b0;
        total++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 4'd3 || cdb_value_o !== 64'd12) begin bad++; $display("FAIL basic_cdb got=%0h/%0h/%0h exp=1/3/c", cdb_valid_o, cdb_idx_o, cdb_value_o); end
        total++; if (cdb_except_raised_o !== 1'b0) begin bad++; $display("FAIL basic_noexc got=%0h exp=0", cdb_except_raised_o); end
        cdb_ready_i = 1'b1;
        @(negedge clk_i);
        cdb_ready_i = 1'b0;
        total++; if (cdb_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL basic_freed got=%0h/%0h exp=0/1", cdb_valid_o, issue_ready_o); end
    endtask

    task automatic test_snoop();
        do_reset();
        issue(OP_SUB, 1'b0, 4'd9, 64'd0, 1'b1, 4'd0, 64'd1, 4'd5);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL snoop_wait1 got=%0h exp=0", eu_valid_o); end
        cdb_valid_i = 1'b1; cdb_idx_i = 4'd8; cdb_value_i = 64'd77;
        @(negedge clk_i);
        total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL snoop_wrong_tag got=%0h exp=0", eu_valid_o); end
        cdb_idx_i = 4'd9; cdb_value_i = 64'd10;
        @(negedge clk_i);
        cdb_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1 || eu_entry_idx_o !== 3'd0) begin bad++; $display("FAIL snoop_dispatch got=%0h idx=%0h exp=1 idx=0", eu_valid_o, eu_entry_idx_o); end
        total++; if (eu_rs1_o !== 64'd10 || eu_rs2_o !== 64'd1 || eu_ctl_o !== OP_SUB) begin bad++; $display("FAIL snoop_operands got=%0h/%0h/%0h exp=a/1/%0h", eu_rs1_o, eu_rs2_o, eu_ctl_o, OP_SUB); end
    endtask

    task automatic test_forward();
        do_reset();
        issue(OP_ADD, 1'b1, 4'd0, 64'h11, 1'b0, 4'd4, 64'd0, 4'd2);
        cdb_valid_i = 1'b1; cdb_idx_i = 4'd4; cdb_value_i = 64'hAA;
        @(negedge clk_i);
        issue_valid_i = 1'b0; cdb_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%0h exp=1", eu_valid_o); end
        total++; if (eu_rs2_o !== 64'hAA || eu_rs1_o !== 64'h11) begin bad++; $display("FAIL fwd_value got=%0h/%0h exp=11/aa", eu_rs1_o, eu_rs2_o); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL full_fill_ready%0d got=%0h exp=1", i, issue_ready_o); end
            issue(OP_ADD, 1'b1, 4'd0, 64'(100 + i), 1'b1, 4'd0, 64'd1, 4'(i));
            @(negedge clk_i);
        end
        issue_valid_i = 1'b0;
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_not_ready got=%0h exp=0", issue_ready_o); end
        issue(OP_ADD, 1'b1, 4'd0, 64'd999, 1'b1, 4'd0, 64'd1, 4'd15);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_still_full got=%0h exp=0", issue_ready_o); end
        total++; if (eu_entry_idx_o !== 3'd0 || eu_rs1_o !== 64'd100) begin bad++; $display("FAIL full_ninth_dropped got=%0h/%0d exp=0/100", eu_entry_idx_o, eu_rs1_o); end
        eu_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        eu_ready_i = 1'b0;
        total++; if (eu_entry_idx_o !== 3'd3 || eu_rs1_o !== 64'd103) begin bad++; $display("FAIL full_dispatch3 got=%0h/%0d exp=3/103", eu_entry_idx_o, eu_rs1_o); end
        eu_valid_i = 1'b1; eu_entry_idx_i = 3'd2; eu_result_i = 64'h22;
        @(negedge clk_i);
        eu_valid_i = 1'b0;
        total++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 4'd2 || cdb_value_o !== 64'h22) begin bad++; $display("FAIL full_cdb2 got=%0h/%0h/%0h exp=1/2/22", cdb_valid_o, cdb_idx_o, cdb_value_o); end
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_grant_cycle got=%0h exp=0", issue_ready_o); end
        cdb_ready_i = 1'b1;
        @(negedge clk_i);
        cdb_ready_i = 1'b0;
        total++; if (issue_ready_o !== 1'b1 || cdb_valid_o !== 1'b0) begin bad++; $display("FAIL full_freed got=%0h/%0h exp=1/0", issue_ready_o, cdb_valid_o); end
        issue(OP_SUB, 1'b1, 4'd0, 64'h55, 1'b1, 4'd0, 64'h66, 4'd12);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_refull got=%0h exp=0", issue_ready_o); end
        total++; if (eu_entry_idx_o !== 3'd2 || eu_rs1_o !== 64'h55 || eu_rs2_o !== 64'h66) begin bad++; $display("FAIL full_reuse2 got=%0h/%0h/%0h exp=2/55/66", eu_entry_idx_o, eu_rs1_o, eu_rs2_o); end
    endtask

    task automatic test_order();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            issue(OP_ADD, (i == 1 || i == 5), 4'd14, 64'(i), 1'b1, 4'd0, 64'd0, 4'(i + 8));
            @(negedge clk_i);
        end
        issue_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1 || eu_entry_idx_o !== 3'd1 || eu_rs1_o !== 64'd1) begin bad++; $display("FAIL order_first got=%0h/%0h/%0h exp=1/1/1", eu_valid_o, eu_entry_idx_o, eu_rs1_o); end
        eu_ready_i = 1'b1;
        @(negedge clk_i);
        total++; if (eu_entry_idx_o !== 3'd5 || eu_rs1_o !== 64'd5) begin bad++; $display("FAIL order_second got=%0h/%0h exp=5/5", eu_entry_idx_o, eu_rs1_o); end
        @(negedge clk_i);
        eu_ready_i = 1'b0;
        total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL order_drained got=%0h exp=0", eu_valid_o); end
        eu_valid_i = 1'b1; eu_entry_idx_i = 3'd5; eu_result_i = 64'h50;
        @(negedge clk_i);
        total++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 4'd13 || cdb_value_o !== 64'h50) begin bad++; $display("FAIL order_cdb5_alone got=%0h/%0h/%0h exp=1/d/50", cdb_valid_o, cdb_idx_o, cdb_value_o); end
        eu_entry_idx_i = 3'd1; eu_result_i = 64'h10;
        @(negedge clk_i);
        eu_valid_i = 1'b0;
        total++; if (cdb_idx_o !== 4'd9 || cdb_value_o !== 64'h10) begin bad++; $display("FAIL order_cdb1_first got=%0h/%0h exp=9/10", cdb_idx_o, cdb_value_o); end
        cdb_ready_i = 1'b1;
        @(negedge clk_i);
        total++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 4'd13 || cdb_value_o !== 64'h50) begin bad++; $display("FAIL order_cdb5_next got=%0h/%0h/%0h exp=1/d/50", cdb_valid_o, cdb_idx_o, cdb_value_o); end
        @(negedge clk_i);
        cdb_ready_i = 1'b0;
        total++; if (cdb_valid_o !== 1'b0) begin bad++; $display("FAIL order_cdb_empty got=%0h exp=0", cdb_valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(OP_ADD, 1'b0, 4'd14, 64'd0, 1'b1, 4'd0, 64'd0, 4'd1);
        @(negedge clk_i);
        issue(OP_ADD, 1'b1, 4'd0, 64'h31, 1'b1, 4'd0, 64'h32, 4'd2);
        @(negedge clk_i);
        issue(OP_SUB, 1'b1, 4'd0, 64'h41, 1'b1, 4'd0, 64'h42, 4'd3);
        eu_ready_i = 1'b1;
        @(negedge clk_i);
        eu_ready_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1 || eu_entry_idx_o !== 3'd2 || eu_rs1_o !== 64'h41) begin bad++; $display("FAIL flush_setup got=%0h/%0h/%0h exp=1/2/41", eu_valid_o, eu_entry_idx_o, eu_rs1_o); end
        issue(OP_ADD, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 64'd1, 4'd7);
        flush_i = 1'b1; eu_valid_i = 1'b1; eu_entry_idx_i = 3'd1; eu_result_i = 64'h77;
        @(negedge clk_i);
        flush_i = 1'b0; issue_valid_i = 1'b0;
        total++; if (issue_ready_o !== 1'b1 || eu_valid_o !== 1'b0 || cdb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_handshakes got=%0h/%0h/%0h exp=1/0/0", issue_ready_o, eu_valid_o, cdb_valid_o); end
        total++; if (eu_rs1_o !== 64'h0 || eu_entry_idx_o !== 3'd0 || cdb_value_o !== 64'h0 || cdb_idx_o !== 4'd0) begin bad++; $display("FAIL flush_data got=%0h/%0h/%0h/%0h exp=0", eu_rs1_o, eu_entry_idx_o, cdb_value_o, cdb_idx_o); end
        eu_result_i = 64'h99;
        @(negedge clk_i);
        eu_valid_i = 1'b0;
        total++; if (cdb_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL flush_stale_wb got=%0h/%0h exp=0/1", cdb_valid_o, issue_ready_o); end
    endtask

    task automatic test_exception();
        do_reset();
        issue(OP_ADD, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 64'd2, 4'd6);
        @(negedge clk_i);
        issue_valid_i = 1'b0; eu_ready_i = 1'b1;
        @(negedge clk_i);
        eu_ready_i = 1'b0;
        eu_valid_i = 1'b1; eu_entry_idx_i = 3'd0; eu_result_i = 64'd0;
        eu_except_raised_i = 1'b1; eu_except_code_i = 2'd2;
        @(negedge clk_i);
        eu_valid_i = 1'b0; eu_except_raised_i = 1'b0; eu_except_code_i = 2'd0;
        total++; if (cdb_valid_o !== 1'b1 || cdb_idx_o !== 4'd6) begin bad++; $display("FAIL exc_cdb got=%0h/%0h exp=1/6", cdb_valid_o, cdb_idx_o); end
        total++; if (cdb_except_raised_o !== 1'b1 || cdb_except_code_o !== 2'd2) begin bad++; $display("FAIL exc_fields got=%0h/%0h exp=1/2", cdb_except_raised_o, cdb_except_code_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(OP_ADD, 1'b1, 4'd0, 64'd3, 1'b1, 4'd0, 64'd4, 4'd1);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        total++; if (eu_valid_o !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0h exp=1", eu_valid_o); end
        #2 rst_n_i = 1'b0;
        #1;
        total++; if (eu_valid_o !== 1'b0 || issue_ready_o !== 1'b1 || eu_rs1_o !== 64'h0) begin bad++; $display("FAIL arst_immediate got=%0h/%0h/%0h exp=0/1/0", eu_valid_o, issue_ready_o, eu_rs1_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_basic();
        test_snoop();
        test_forward();
        test_full();
        test_order();
        test_flush();
        test_exception();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
